// File: rtl/pattern_tx_pkg.sv
// -----------------------------------------------------------------------------
// pattern_tx_pkg
// Shared definitions for the pattern_tx serial transmitter:
//   - state_t        : binary FSM encoding (IDLE=00, SHIFT=01, PARITY=10, DONE=11)
//   - len_width()    : width of the length field for a given pattern width
//   - DEFAULT_WIDTH  : default maximum pattern length in bits
//   - DEFAULT_LEN_W  : length-field width for DEFAULT_WIDTH
// -----------------------------------------------------------------------------
package pattern_tx_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_SHIFT  = 2'b01,
        S_PARITY = 2'b10,
        S_DONE   = 2'b11
    } state_t;

    // The length field must be able to express every value 0..width.
    function automatic int len_width(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_LEN_W = len_width(DEFAULT_WIDTH);

endpackage

// File: rtl/pattern_tx_if.sv
// -----------------------------------------------------------------------------
// pattern_tx_if
// Request/serial-output bundle of pattern_tx.
//   start, pattern, len        : request side (driven by master)
//   w, valid, busy, done, states : transmitter status and serial line (slave)
// Modports: master (requester / bench), slave (pattern_tx).
// -----------------------------------------------------------------------------
interface pattern_tx_if
    import pattern_tx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    localparam int LEN_W = len_width(WIDTH);

    logic             start;
    logic [WIDTH-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic             w;
    logic             valid;
    logic             busy;
    logic             done;
    logic [1:0]       states;

    modport master (
        output start, pattern, len,
        input  w, valid, busy, done, states
    );

    modport slave (
        input  start, pattern, len,
        output w, valid, busy, done, states
    );

endinterface

// File: rtl/pattern_tx_bit_counter.sv
// -----------------------------------------------------------------------------
// bit_counter
// Down-counter tracking how many pattern bits remain to be sent.
//   clk, reset : clock, asynchronous active-high reset (count -> 0)
//   load       : load load_val (has priority over dec)
//   load_val   : value to load
//   dec        : decrement by one (saturates at zero)
//   count      : current count
//   is_one     : count == 1, i.e. the bit on the line is the last one
// -----------------------------------------------------------------------------
module bit_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         is_one
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and infers a latch.
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all
            // flops update together from values sampled before the edge.
            count_q <= count_d;
        end
    end

    assign count  = count_q;
    assign is_one = (count_q == W'(1));

endmodule

// File: rtl/pattern_tx.sv
// -----------------------------------------------------------------------------
// pattern_tx
// Serialises up to WIDTH bits of a pattern, LSB first, on line w. A request
// (start with len != 0) is accepted only in IDLE; len is clamped to WIDTH.
// Every transmission ends with a one-cycle done pulse in the DONE state.
// All outputs are registered and computed from the next state.
//   clk    : rising-edge clock
//   reset  : asynchronous active-high reset
//   bus    : pattern_tx_if.slave (start/pattern/len in; w/valid/busy/done/states out)
// Build option: define PATTERN_TX_PARITY_EN to append an even-parity bit
// (PARITY state) after the data bits.
// -----------------------------------------------------------------------------
module pattern_tx
    import pattern_tx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic        clk,
    input  logic        reset,
    pattern_tx_if.slave bus
);

    localparam int               LEN_W     = len_width(WIDTH);
    localparam logic [LEN_W-1:0] WIDTH_LEN = LEN_W'(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic             w_q, w_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef PATTERN_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    logic             cnt_load;
    logic             cnt_dec;
    logic [LEN_W-1:0] cnt_load_val;
    logic [LEN_W-1:0] cnt_count;
    logic             cnt_is_one;

    // Over-long requests are clamped so the counter never exceeds the register.
    assign cnt_load_val = (bus.len > WIDTH_LEN) ? WIDTH_LEN : bus.len;

    bit_counter #(
        .W (LEN_W)
    ) u_bit_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .count    (cnt_count),
        .is_one   (cnt_is_one)
    );

    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
`ifdef PATTERN_TX_PARITY_EN
        par_d    = par_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (bus.start && (bus.len != '0)) begin
                    state_d  = S_SHIFT;
                    sreg_d   = bus.pattern;
                    cnt_load = 1'b1;
`ifdef PATTERN_TX_PARITY_EN
                    par_d    = 1'b0;
`endif
                end
            end
            S_SHIFT: begin
                sreg_d  = sreg_q >> 1;
                cnt_dec = 1'b1;
`ifdef PATTERN_TX_PARITY_EN
                par_d   = par_q ^ sreg_q[0];
`endif
                // A zero count cannot occur here; treating it as "last bit"
                // keeps the FSM from ever shifting without end.
                if (cnt_is_one || (cnt_count == '0)) begin
`ifdef PATTERN_TX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_DONE;
`endif
                end
            end
            S_PARITY: begin
`ifdef PATTERN_TX_PARITY_EN
                state_d = S_DONE;
`else
                state_d = S_IDLE;
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered, so they are derived from the next state
        // and line up with the state they describe.
        w_d     = 1'b0;
        valid_d = 1'b0;
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
        if (state_d == S_SHIFT) begin
            w_d     = sreg_d[0];
            valid_d = 1'b1;
        end
`ifdef PATTERN_TX_PARITY_EN
        else if (state_d == S_PARITY) begin
            w_d     = par_d;
            valid_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the data register is reset too, so an aborted transfer
            // leaves no stale bits behind.
            state_q <= S_IDLE;
            sreg_q  <= '0;
            w_q     <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef PATTERN_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            w_q     <= w_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef PATTERN_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign bus.w      = w_q;
    assign bus.valid  = valid_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.states = state_q;

endmodule

// File: tb/tb_pattern_tx.sv
// -----------------------------------------------------------------------------
// tb_pattern_tx
// Self-checking bench for pattern_tx. The stimulus side decides, from the
// transmitter's documented timing, when a request is accepted and queues the
// expected serial events (bit value + cycle, parity, done). An independent
// negedge monitor pops the queue and compares w/valid/done/busy/states.
// Honours PATTERN_TX_PARITY_EN like the design.
// -----------------------------------------------------------------------------
module tb_pattern_tx;
    import pattern_tx_pkg::*;

    localparam int W  = 8;
    localparam int LW = len_width(W);
`ifdef PATTERN_TX_PARITY_EN
    localparam int PE = 1;
`else
    localparam int PE = 0;
`endif

    logic clk;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    pattern_tx_if #(.WIDTH(W)) bus ();

    pattern_tx #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    // ---------------- reference model ----------------
    typedef struct {
        bit   is_done;
        logic val;
        int   cyc;
    } ev_t;

    ev_t q[$];
    int  bfrom = -100;   // first SHIFT cycle of current transmission
    int  bn    = 0;      // clamped length
    int  bend  = -100;   // DONE cycle
    int  next_free = 0;  // first edge at which a new start is accepted

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_accept(input int k, input logic [W-1:0] p, input logic [LW-1:0] l);
        int   n;
        logic par;
        n   = (int'(l) > W) ? W : int'(l);
        par = 1'b0;
        for (int i = 0; i < n; i++) begin
            q.push_back('{1'b0, p[i], k + i});
            par ^= p[i];
        end
        if (PE != 0) q.push_back('{1'b0, par, k + n});
        q.push_back('{1'b1, 1'b0, k + n + PE});
        bfrom     = k;
        bn        = n;
        bend      = k + n + PE;
        next_free = bend + 2;   // DONE, then one IDLE cycle
    endtask

    task automatic model_reset();
        q.delete();
        bfrom     = -100;
        bn        = 0;
        bend      = -100;
        next_free = 0;
    endtask

    function automatic logic exp_busy(input int c);
        return (c >= bfrom) && (c <= bend);
    endfunction

    function automatic logic [1:0] exp_states(input int c);
        if (c < bfrom || c > bend) return 2'b00;
        if (c < bfrom + bn)        return 2'b01;
        if (c == bend)             return 2'b11;
        return 2'b10;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!reset) begin
            ev_t  e;
            logic has;
            int   c;
            c   = cyc;
            has = 1'b0;
            if (q.size() != 0 && q[0].cyc == c) begin
                e   = q.pop_front();
                has = 1'b1;
            end
            check("valid", bus.valid, has && !e.is_done);
            check("w", bus.w, (has && !e.is_done) ? e.val : 1'b0);
            check("done", bus.done, has && e.is_done);
            check("busy", bus.busy, exp_busy(c));
            check("states", bus.states, exp_states(c));
        end
    end

    // ---------------- stimulus ----------------
    // Called at a negedge; the next rising edge is edge cyc+1.
    task automatic drive_cycle(input logic s, input logic [W-1:0] p, input logic [LW-1:0] l);
        int k;
        bus.start   = s;
        bus.pattern = p;
        bus.len     = l;
        k = cyc + 1;
        if (s && (l != '0) && (k >= next_free)) model_accept(k, p, l);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, W'($urandom), LW'($urandom));
    endtask

    task automatic send(input logic [W-1:0] p, input logic [LW-1:0] l);
        drive_cycle(1'b1, p, l);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_w"},      bus.w, 1'b0);
        check({tag, "_valid"},  bus.valid, 1'b0);
        check({tag, "_busy"},   bus.busy, 1'b0);
        check({tag, "_done"},   bus.done, 1'b0);
        check({tag, "_states"}, bus.states, 2'b00);
    endtask

    initial begin
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.pattern = '0;
        bus.len     = '0;
        @(negedge clk);
        #1 check_cleared("reset");
        #1 reset = 1'b0;
        @(negedge clk);

        // Reference transmission 0xB2, len 8: 0,1,0,0,1,1,0,1 then done.
        send(8'hB2, LW'(8));
        idle(12);

        // Three data bits of ones; with parity the fourth bit is 1.
        send(8'h07, LW'(3));
        idle(8);

        // Zero-length requests are ignored.
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 8'hFF, '0);
        idle(2);

        // Over-long request is clamped to 8 bits.
        send(8'h96, LW'(12));
        idle(14);

        // Reset in the third SHIFT cycle aborts with no done pulse.
        send(8'hC3, LW'(8));
        idle(2);
        #2 reset = 1'b1;
        model_reset();
        #1 check_cleared("midreset");
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        send(8'h5A, LW'(8));
        idle(12);

        // Start held high: back-to-back with one IDLE cycle, then start
        // toggling and pattern changes while busy.
        for (int i = 0; i < 12; i++) drive_cycle(1'b1, 8'h02, LW'(2));
        for (int i = 0; i < 12; i++) drive_cycle(i[0], W'($urandom), LW'(2));
        idle(6);

        // Random traffic, including len values above WIDTH.
        for (int i = 0; i < 800; i++) begin
            drive_cycle(($urandom_range(0, 2) == 0), W'($urandom),
                        LW'($urandom_range(0, (1 << LW) - 1)));
        end

        // Bounded drain: the longest transmission fits well inside this.
        idle(W + 6);
        check("final_busy", bus.busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pattern_tx.md
PATTERN_TX -- requirements
Module: pattern_tx

Interface
- REQ-001 Parameter: WIDTH, default 8, maximum pattern length in bits (range 2..16).
- REQ-002 Port: clk  input  1  single rising-edge clock.
- REQ-003 Port: reset  input  1  asynchronous, active-high reset.
- REQ-004 Port: start  input  1  request to transmit; sampled only in IDLE.
- REQ-005 Port: pattern  input  WIDTH  bits to send, LSB first; captured on the accepted start.
- REQ-006 Port: len  input  ceil(log2(WIDTH+1))  number of bits to send; captured on the accepted start.
- REQ-007 Port: w  output  1  serial data line.
- REQ-008 Port: valid  output  1  high while w carries a pattern or parity bit.
- REQ-009 Port: busy  output  1  high in every state except IDLE.
- REQ-010 Port: done  output  1  one-cycle pulse at the end of a transmission.
- REQ-011 Port: states  output  2  current state encoding, for debug and LEDs.

Function
- REQ-012 The FSM SHALL be binary encoded: IDLE=00, SHIFT=01, PARITY=10, DONE=11.
- REQ-013 IDLE: when start=1 and len!=0, the block SHALL load pattern into the shift register, load the bit counter with min(len, WIDTH), and go to SHIFT.
- REQ-014 IDLE: when start=1 and len=0, the request SHALL be ignored; the FSM stays in IDLE and done stays 0.
- REQ-015 SHIFT: w SHALL equal shift register bit 0 and valid SHALL be 1.
- REQ-016 SHIFT: on each clock edge the register SHALL shift right, fill with 0, and the counter SHALL decrement.
- REQ-017 SHIFT: when the counter equals 1, the next state SHALL be PARITY if enabled (see REQ-025), otherwise DONE.
- REQ-018 DONE: done=1, valid=0, w=0 for exactly one cycle; the next state SHALL be IDLE unconditionally.
- REQ-019 Outside SHIFT and PARITY, w=0 and valid=0.
- REQ-020 Latency: for a start accepted at edge k, bit i SHALL appear on w in cycle k+1+i. done SHALL be high in cycle k+n+1 without parity and k+n+2 with parity, where n is the clamped length.
- REQ-021 start asserted while busy=1 SHALL be ignored, and SHALL not be queued. Changes to pattern or len while busy SHALL not affect the transmission in progress.
- REQ-022 Back-to-back: start held high SHALL begin a new transmission on the edge after DONE, leaving one IDLE cycle between transmissions.

Reset
- REQ-023 Asserting reset SHALL immediately force IDLE, shift register=0, counter=0, w=0, valid=0, busy=0, done=0, and states=00, including mid-transmission.
- REQ-024 After reset deasserts, the first start SHALL be accepted normally; no partial transmission SHALL resume.

Configuration
- REQ-025 With macro PATTERN_TX_PARITY_EN defined:
  - the PARITY state exists;
  - in PARITY, w SHALL be the even-parity bit (XOR of the n bits sent) with valid=1, lasting one cycle;
  - a running parity register SHALL accumulate each transmitted bit.
- REQ-026 Without PATTERN_TX_PARITY_EN: PARITY SHALL be unreachable, the parity register SHALL not exist, and SHIFT SHALL go directly to DONE.

Structure
- REQ-027 A shared package pattern_tx_pkg SHALL hold the four state-encoding constants and the length-width helper constant.
- REQ-028 The bit counter SHALL be a sub-module named bit_counter, with these ports:
  - load, load value, decrement enable;
  - count output and is_one flag;
  - async active-high reset, matching REQ-023.
- REQ-029 State and data registers SHALL use the team's existing dff cell or equivalent async-reset flops, with reset value 0.

Verification
- REQ-030 WIDTH=8, pattern=8'b1011_0010, len=8, start pulse at edge k:
  - w in cycles k+1..k+8 = 0,1,0,0,1,1,0,1 with valid=1;
  - done=1 in cycle k+9 (parity off).
- REQ-031 PARITY_EN defined, pattern=8'h07, len=3: w = 1,1,1 then parity bit 1; done in cycle k+5.
- REQ-032 len=0 with start=1 for 3 cycles: busy, valid and done stay 0, and states stays 00.
- REQ-033 len=12 with WIDTH=8: exactly 8 bits are sent (clamped), followed by done.
- REQ-034 reset asserted during the 3rd SHIFT cycle: w, valid and busy drop to 0 asynchronously, with no done pulse. A new start after release sends the full new pattern.
- REQ-035 start held high, len=2, pattern=2'b10: w is 0,1, then DONE, one IDLE cycle, then 0,1 again. start toggled mid-SHIFT has no effect.
